// File: rtl/mandelbrot_pkg.sv
// Shared constants, FSM state type and grey-level mapping for the Mandelbrot render controller.
package mandelbrot_pkg;

   localparam int unsigned GRID_W   = 160;
   localparam int unsigned GRID_H   = 120;
   localparam int unsigned ITER_W   = 6;
   localparam int unsigned ITER_MAX = (1 << ITER_W) - 1;
   localparam int unsigned MAX_OUT  = 8;
   localparam int unsigned FB_AW    = 15;
   localparam int unsigned NUM_PIX  = GRID_W * GRID_H;
   localparam int unsigned CNT_W    = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } state_e;

   // Points inside the set are drawn black; others scale the count into the upper grey bits.
   function automatic logic [7:0] iter_to_grey(input logic [ITER_W-1:0] iter);
      logic [7:0] grey;
      if (iter == ITER_W'(ITER_MAX)) begin
         grey = 8'd0;
      end else begin
         grey = {iter, {(8 - ITER_W){1'b0}}};
      end
      return grey;
   endfunction

endpackage

// File: rtl/mandelbrot_credit_cnt.sv
// Outstanding-request counter: limits in-flight engine requests to MaxOut.
module mandelbrot_credit_cnt #(
   parameter int unsigned MaxOut = 8,
   parameter int unsigned CntW   = $clog2(MaxOut + 1)
) (
   input  logic clk_pix_1x,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic can_issue,
   output logic nonzero
);

   logic [CntW-1:0] count_q;

   // Count up on issue, down on result; both together leave the count unchanged.
   always_ff @(posedge clk_pix_1x) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc && !dec) begin
         count_q <= count_q + CntW'(1);
      end else if (dec && !inc) begin
         count_q <= count_q - CntW'(1);
      end
   end

   assign can_issue = (count_q < CntW'(MaxOut));
   assign nonzero   = (count_q != '0);

endmodule

// File: rtl/mandelbrot_render_ctrl.sv
// Render sequencer: scans the grid into the iteration engine and writes results to the framebuffer.
module mandelbrot_render_ctrl
   import mandelbrot_pkg::*;
(
   input  logic              clk_pix_1x,
   input  logic              rst,
   input  logic              frame_start,
   input  logic [7:0]        cfg_zoom,
   output logic              eng_valid,
   input  logic              eng_ready,
   output logic [7:0]        eng_x,
   output logic [6:0]        eng_y,
   output logic [7:0]        eng_zoom,
   input  logic              res_valid,
   input  logic [ITER_W-1:0] res_iter,
   output logic              fb_we,
   output logic [FB_AW-1:0]  fb_addr,
   output logic [7:0]        fb_data,
   output logic              busy,
   output logic              done,
   output logic              err_spurious
);

   state_e           state_q, state_d;
   logic [7:0]       x_q;
   logic [6:0]       y_q;
   logic [FB_AW-1:0] wr_addr_q;
   logic [7:0]       zoom_q;
   logic             zoom_valid_q;
   logic             fb_we_q;
   logic [FB_AW-1:0] fb_addr_q;
   logic [7:0]       fb_data_q;
   logic             err_q;

   logic can_issue, has_out;
   logic hs, res_acc, start, last_col, last_row;

   assign eng_valid = (state_q == StIssue) && can_issue;
   assign hs        = eng_valid && eng_ready;
   // Results with nothing outstanding are stale (e.g. left over from an aborted render).
   assign res_acc   = res_valid && has_out;
   assign last_col  = (x_q == 8'(GRID_W - 1));
   assign last_row  = (y_q == 7'(GRID_H - 1));
   assign start     = (state_q == StIdle) && frame_start &&
                      (!zoom_valid_q || (cfg_zoom != zoom_q));

   mandelbrot_credit_cnt #(
      .MaxOut (MAX_OUT),
      .CntW   (CNT_W)
   ) u_credit (
      .clk_pix_1x (clk_pix_1x),
      .rst        (rst),
      .inc        (hs),
      .dec        (res_acc),
      .can_issue  (can_issue),
      .nonzero    (has_out)
   );

   // FSM state register.
   always_ff @(posedge clk_pix_1x) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StIssue;
         StIssue: if (hs && last_col && last_row) state_d = StDrain;
         StDrain: if (!has_out && (wr_addr_q == FB_AW'(NUM_PIX))) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Zoom latch and row-major scan position of the next request.
   always_ff @(posedge clk_pix_1x) begin
      if (rst) begin
         zoom_q       <= '0;
         zoom_valid_q <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
      end else if (start) begin
         zoom_q       <= cfg_zoom;
         zoom_valid_q <= 1'b1;
         x_q          <= '0;
         y_q          <= '0;
      end else if (hs) begin
         if (last_col) begin
            x_q <= '0;
            y_q <= last_row ? '0 : y_q + 7'd1;
         end else begin
            x_q <= x_q + 8'd1;
         end
      end
   end

   // Write pointer and registered framebuffer write port; results are accepted every cycle.
   always_ff @(posedge clk_pix_1x) begin
      if (rst) begin
         wr_addr_q <= '0;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         fb_we_q <= res_acc;
         if (res_acc) begin
            fb_addr_q <= wr_addr_q;
            fb_data_q <= iter_to_grey(res_iter);
         end
         if (start) begin
            wr_addr_q <= '0;
         end else if (res_acc) begin
            wr_addr_q <= wr_addr_q + FB_AW'(1);
         end
         if (res_valid && !has_out) begin
            err_q <= 1'b1;
         end
      end
   end

   assign eng_x        = x_q;
   assign eng_y        = y_q;
   assign eng_zoom     = zoom_q;
   assign fb_we        = fb_we_q;
   assign fb_addr      = fb_addr_q;
   assign fb_data      = fb_data_q;
   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign err_spurious = err_q;

endmodule

// File: tb/tb_mandelbrot_render_ctrl.sv
// Self-checking bench for mandelbrot_render_ctrl with a behavioural engine and scoreboard.
module tb_mandelbrot_render_ctrl;

   localparam int W     = 160;
   localparam int H     = 120;
   localparam int N_PIX = W * H;

   logic        clk_pix_1x = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic [7:0]  cfg_zoom = 8'h00;
   logic        eng_valid;
   logic        eng_ready = 1'b0;
   logic [7:0]  eng_x;
   logic [6:0]  eng_y;
   logic [7:0]  eng_zoom;
   logic        res_valid = 1'b0;
   logic [5:0]  res_iter = 6'd0;
   logic        fb_we;
   logic [14:0] fb_addr;
   logic [7:0]  fb_data;
   logic        busy;
   logic        done;
   logic        err_spurious;

   mandelbrot_render_ctrl dut (
      .clk_pix_1x   (clk_pix_1x),
      .rst          (rst),
      .frame_start  (frame_start),
      .cfg_zoom     (cfg_zoom),
      .eng_valid    (eng_valid),
      .eng_ready    (eng_ready),
      .eng_x        (eng_x),
      .eng_y        (eng_y),
      .eng_zoom     (eng_zoom),
      .res_valid    (res_valid),
      .res_iter     (res_iter),
      .fb_we        (fb_we),
      .fb_addr      (fb_addr),
      .fb_data      (fb_data),
      .busy         (busy),
      .done         (done),
      .err_spurious (err_spurious)
   );

   always #5 clk_pix_1x = ~clk_pix_1x;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int ready_mode = 1;  // 0 never ready, 1 always ready, 2 random 50%
   int lat = 4;
   bit hold = 1'b0;     // engine withholds results
   bit mon_en = 1'b0;   // scoreboard expects legitimate traffic

   typedef struct {int idx; int due;} req_t;
   typedef struct {int idx; int cyc;} res_t;
   req_t pend[$];
   res_t wq[$];

   int hs_idx = 0;      // expected index of next request (row-major)
   int wr_idx = 0;      // expected next framebuffer address
   int out_cnt = 0;     // requests accepted but not yet answered
   int last_wr_cyc = -1;
   bit stall_q = 1'b0;
   logic [7:0] stall_x;
   logic [6:0] stall_y;

   function automatic int iter_of(input int idx);
      case (idx % 7)
         0:       return 63;
         1:       return 5;
         default: return (idx * 13) % 63;
      endcase
   endfunction

   function automatic int grey_ref(input int it);
      return (it == 63) ? 0 : it * 4;
   endfunction

   // Engine model: outstanding bookkeeping on the edge, then drive ready/results for the next cycle.
   always @(posedge clk_pix_1x) begin
      if (rst) begin
         out_cnt = 0;
      end else begin
         if (res_valid && out_cnt > 0) out_cnt = out_cnt - 1;
         if (eng_valid && eng_ready) out_cnt = out_cnt + 1;
      end
      cyc = cyc + 1;
      #1;
      case (ready_mode)
         0:       eng_ready = 1'b0;
         1:       eng_ready = 1'b1;
         default: eng_ready = 1'($urandom_range(0, 1));
      endcase
      if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
         res_t r;
         res_valid = 1'b1;
         res_iter  = 6'(iter_of(pend[0].idx));
         r.idx = pend[0].idx;
         r.cyc = cyc;
         if (mon_en) wq.push_back(r);
         void'(pend.pop_front());
      end else begin
         res_valid = 1'b0;
      end
   end

   // Monitor: request order, stall stability, credit limit and framebuffer writes.
   always @(negedge clk_pix_1x) begin
      bit hs;
      if (wq.size() > 0 && wq[0].cyc + 1 == cyc) begin
         checks++;
         if (fb_we !== 1'b1 || fb_addr !== 15'(wr_idx) ||
             fb_data !== 8'(grey_ref(iter_of(wq[0].idx)))) begin
            errors++;
            $display("FAIL write: we=%b addr=%0d data=%02h, required we=1 addr=%0d data=%02h",
                     fb_we, fb_addr, fb_data, wr_idx, grey_ref(iter_of(wq[0].idx)));
         end
         if (wr_idx == N_PIX - 1) last_wr_cyc = cyc;
         wr_idx++;
         void'(wq.pop_front());
      end else begin
         checks++;
         if (fb_we !== 1'b0) begin
            errors++;
            $display("FAIL no_write: fb_we=%b addr=%0d at cycle %0d, required fb_we=0",
                     fb_we, fb_addr, cyc);
         end
      end
      if (eng_valid === 1'b1) begin
         checks++;
         if (out_cnt >= 8) begin
            errors++;
            $display("FAIL credit: eng_valid=1 with %0d outstanding, required below 8", out_cnt);
         end
      end
      if (stall_q) begin
         checks++;
         if (eng_valid !== 1'b1 || eng_x !== stall_x || eng_y !== stall_y) begin
            errors++;
            $display("FAIL stall_stable: valid=%b x=%0d y=%0d, required valid=1 x=%0d y=%0d",
                     eng_valid, eng_x, eng_y, stall_x, stall_y);
         end
      end
      stall_q = (eng_valid === 1'b1) && (eng_ready === 1'b0);
      stall_x = eng_x;
      stall_y = eng_y;
      hs = (eng_valid === 1'b1) && (eng_ready === 1'b1);
      if (hs) begin
         req_t r;
         if (mon_en) begin
            checks++;
            if (eng_x !== 8'(hs_idx % W) || eng_y !== 7'(hs_idx / W)) begin
               errors++;
               $display("FAIL coord: x=%0d y=%0d, required x=%0d y=%0d",
                        eng_x, eng_y, hs_idx % W, hs_idx / W);
            end
         end
         hs_idx++;
         r.idx = int'(eng_y) * W + int'(eng_x);
         r.due = cyc + lat;
         pend.push_back(r);
      end
   end

   task automatic pulse_start(input logic [7:0] z);
      @(posedge clk_pix_1x); #1;
      cfg_zoom    = z;
      frame_start = 1'b1;
      @(posedge clk_pix_1x); #1;
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen, output int at);
      seen = 1'b0;
      at   = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk_pix_1x);
         if (done === 1'b1) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ready_mode = 1;
      repeat (3) @(posedge clk_pix_1x);
      @(negedge clk_pix_1x);
      checks++;
      if ({eng_valid, eng_x, eng_y, eng_zoom, fb_we, fb_addr, fb_data, busy, done,
           err_spurious} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b x=%0d y=%0d zoom=%02h we=%b busy=%b done=%b err=%b",
                  eng_valid, eng_x, eng_y, eng_zoom, fb_we, busy, done, err_spurious);
      end
      @(posedge clk_pix_1x); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk_pix_1x);
      checks++;
      if (busy !== 1'b0 || eng_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b eng_valid=%b, required 0 0", busy, eng_valid);
      end
      hs_idx = 0;
      wr_idx = 0;
      mon_en = 1'b1;
      pulse_start(8'h00);
      @(negedge clk_pix_1x);
      checks++;
      if (busy !== 1'b1 || eng_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_start: busy=%b eng_valid=%b, required 1 1", busy, eng_valid);
      end
   endtask

   task automatic test_full_frame();
      bit seen;
      int at;
      wait_done(25000, seen, at);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL full_done: done not seen within 25000 cycles, required a pulse");
      end
      checks++;
      if (at !== last_wr_cyc + 1) begin
         errors++;
         $display("FAIL done_timing: done at cycle %0d, required %0d", at, last_wr_cyc + 1);
      end
      checks++;
      if (hs_idx !== N_PIX || wr_idx !== N_PIX) begin
         errors++;
         $display("FAIL full_counts: handshakes=%0d writes=%0d, required %0d each",
                  hs_idx, wr_idx, N_PIX);
      end
      @(negedge clk_pix_1x);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_done: done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_backpressure();
      bit seen;
      int at;
      ready_mode = 2;
      hs_idx = 0;
      wr_idx = 0;
      pulse_start(8'h11);
      @(negedge clk_pix_1x);
      checks++;
      if (eng_zoom !== 8'h11 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_start: zoom=%02h busy=%b, required 11 1", eng_zoom, busy);
      end
      wait_done(60000, seen, at);
      checks++;
      if (!seen || hs_idx !== N_PIX || wr_idx !== N_PIX) begin
         errors++;
         $display("FAIL bp_frame: done=%b handshakes=%0d writes=%0d, required 1 %0d %0d",
                  seen, hs_idx, wr_idx, N_PIX, N_PIX);
      end
      ready_mode = 1;
   endtask

   task automatic test_credit();
      int n;
      hold = 1'b1;
      hs_idx = 0;
      wr_idx = 0;
      pulse_start(8'h00);
      repeat (40) @(negedge clk_pix_1x);
      checks++;
      if (hs_idx !== 8 || eng_valid !== 1'b0) begin
         errors++;
         $display("FAIL credit_hold: handshakes=%0d eng_valid=%b, required 8 0", hs_idx, eng_valid);
      end
      hold = 1'b0;
      n = 0;
      while (hs_idx <= 8 && n < 30) begin
         @(negedge clk_pix_1x);
         n++;
      end
      checks++;
      if (hs_idx <= 8) begin
         errors++;
         $display("FAIL credit_resume: handshakes=%0d after release, required more than 8", hs_idx);
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_pix_1x);
         checks++;
         if (eng_valid !== 1'(out_cnt < 8)) begin
            errors++;
            $display("FAIL credit_gate: eng_valid=%b with %0d outstanding, required %b",
                     eng_valid, out_cnt, out_cnt < 8);
         end
      end
   endtask

   task automatic test_retrigger();
      bit seen;
      int at;
      pulse_start(8'h55);
      @(negedge clk_pix_1x);
      checks++;
      if (eng_zoom !== 8'h00 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrender_start: zoom=%02h busy=%b, required 00 1", eng_zoom, busy);
      end
      cfg_zoom = 8'h00;
      wait_done(25000, seen, at);
      checks++;
      if (!seen || hs_idx !== N_PIX || wr_idx !== N_PIX) begin
         errors++;
         $display("FAIL credit_frame: done=%b handshakes=%0d writes=%0d, required 1 %0d %0d",
                  seen, hs_idx, wr_idx, N_PIX, N_PIX);
      end
      pulse_start(8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_pix_1x);
         checks++;
         if (busy !== 1'b0 || eng_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_zoom: busy=%b eng_valid=%b, required 0 0", busy, eng_valid);
         end
      end
      hs_idx = 0;
      wr_idx = 0;
      pulse_start(8'h3C);
      @(negedge clk_pix_1x);
      checks++;
      if (busy !== 1'b1 || eng_zoom !== 8'h3C) begin
         errors++;
         $display("FAIL new_zoom: busy=%b zoom=%02h, required 1 3c", busy, eng_zoom);
      end
   endtask

   task automatic test_abort();
      int n;
      n = 0;
      while (hs_idx < 5000 && n < 12000) begin
         @(negedge clk_pix_1x);
         n++;
      end
      checks++;
      if (hs_idx < 5000) begin
         errors++;
         $display("FAIL abort_reach: handshakes=%0d, required 5000", hs_idx);
      end
      hold   = 1'b1;
      mon_en = 1'b0;
      @(posedge clk_pix_1x); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk_pix_1x);
      @(negedge clk_pix_1x);
      checks++;
      if ({eng_valid, eng_x, eng_y, eng_zoom, fb_we, fb_addr, fb_data, busy, done,
           err_spurious} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: valid=%b x=%0d y=%0d zoom=%02h we=%b busy=%b err=%b",
                  eng_valid, eng_x, eng_y, eng_zoom, fb_we, busy, err_spurious);
      end
      @(posedge clk_pix_1x); #1;
      rst  = 1'b0;
      hold = 1'b0;
      n = 0;
      while (pend.size() > 0 && n < 50) begin
         @(negedge clk_pix_1x);
         n++;
      end
      repeat (2) @(negedge clk_pix_1x);
      checks++;
      if (err_spurious !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL spurious: err_spurious=%b busy=%b, required 1 0", err_spurious, busy);
      end
      hs_idx = 0;
      wr_idx = 0;
      mon_en = 1'b1;
      pulse_start(8'h3C);
      @(negedge clk_pix_1x);
      checks++;
      if (busy !== 1'b1 || eng_x !== 8'd0 || eng_y !== 7'd0) begin
         errors++;
         $display("FAIL restart: busy=%b x=%0d y=%0d, required 1 0 0", busy, eng_x, eng_y);
      end
      repeat (40) @(negedge clk_pix_1x);
      checks++;
      if (hs_idx < 20 || wr_idx < 10 || err_spurious !== 1'b1) begin
         errors++;
         $display("FAIL restart_progress: handshakes=%0d writes=%0d err=%b, required >=20 >=10 1",
                  hs_idx, wr_idx, err_spurious);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_credit();
      test_retrigger();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
